// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cdb_arbiter
// Purpose : Round-robin arbiter for the common result broadcast bus
//           (ALU vs branch).
//           Each source has a one-entry holding register for a losing result.
// Revision: 1.0
// ============================================================================
module cdb_arbiter #(
  parameter int WIDTH = 31,
  parameter int ROB   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             redirect,
  input  logic             aluDataBusReq,
  input  logic [WIDTH:0]   aluResult,
  input  logic [ROB:0]     aluRob,
  output logic             aluAck,
  input  logic             branchDataBusReq,
  input  logic [WIDTH:0]   branchResult,
  input  logic [ROB:0]     branchRob,
  output logic             branchAck,
  output logic             validBroadcast,
  output logic [WIDTH:0]   valueBroadcast,
  output logic [ROB:0]     robBroadcast,
  output logic [7:0]       conflictCount
);

  localparam logic [7:0] C_COUNT_MAX = 8'hFF;

  logic           r_aluHoldValid;
  logic [WIDTH:0] r_aluHoldValue;
  logic [ROB:0]   r_aluHoldRob;
  logic           r_brHoldValid;
  logic [WIDTH:0] r_brHoldValue;
  logic [ROB:0]   r_brHoldRob;
  logic           r_lastWinBr;

  logic           w_aluCand;
  logic [WIDTH:0] w_aluValue;
  logic [ROB:0]   w_aluTag;
  logic           w_brCand;
  logic [WIDTH:0] w_brValue;
  logic [ROB:0]   w_brTag;
  logic           w_conflict;
  logic           w_brWins;
  logic           w_anyCand;

  // A held result always takes precedence over a fresh request from the same source.
  always_comb begin
    w_aluCand  = r_aluHoldValid | aluDataBusReq;
    w_aluValue = r_aluHoldValid ? r_aluHoldValue : aluResult;
    w_aluTag   = r_aluHoldValid ? r_aluHoldRob   : aluRob;
    w_brCand   = r_brHoldValid  | branchDataBusReq;
    w_brValue  = r_brHoldValid  ? r_brHoldValue  : branchResult;
    w_brTag    = r_brHoldValid  ? r_brHoldRob    : branchRob;
    w_conflict = w_aluCand & w_brCand;
    w_anyCand  = w_aluCand | w_brCand;
    w_brWins   = w_conflict ? ~r_lastWinBr : w_brCand;
    aluAck     = aluDataBusReq    & ~r_aluHoldValid & ~redirect;
    branchAck  = branchDataBusReq & ~r_brHoldValid  & ~redirect;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      validBroadcast <= 1'b0;
      valueBroadcast <= '0;
      robBroadcast   <= '0;
      r_lastWinBr    <= 1'b0;
      conflictCount  <= '0;
    end else if (redirect) begin
      validBroadcast <= 1'b0;
    end else begin
      validBroadcast <= w_anyCand;
      if (w_anyCand) begin
        valueBroadcast <= w_brWins ? w_brValue : w_aluValue;
        robBroadcast   <= w_brWins ? w_brTag   : w_aluTag;
        r_lastWinBr    <= w_brWins;
      end
      if (w_conflict && (conflictCount != C_COUNT_MAX)) begin
        conflictCount <= conflictCount + 8'd1;
      end
    end
  end

  // An acked request that loses arbitration is parked; a winning holder drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_aluHoldValid <= 1'b0;
      r_aluHoldValue <= '0;
      r_aluHoldRob   <= '0;
      r_brHoldValid  <= 1'b0;
      r_brHoldValue  <= '0;
      r_brHoldRob    <= '0;
    end else if (redirect) begin
      r_aluHoldValid <= 1'b0;
      r_brHoldValid  <= 1'b0;
    end else if (w_brWins) begin
      r_brHoldValid <= 1'b0;
      if (aluAck) begin
        r_aluHoldValid <= 1'b1;
        r_aluHoldValue <= aluResult;
        r_aluHoldRob   <= aluRob;
      end
    end else if (w_aluCand) begin
      r_aluHoldValid <= 1'b0;
      if (branchAck) begin
        r_brHoldValid <= 1'b1;
        r_brHoldValue <= branchResult;
        r_brHoldRob   <= branchRob;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdb_arbiter
// Purpose : Self-checking bench for cdb_arbiter (vector table + scoreboard).
// Revision: 1.0
// ============================================================================
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic        aluDataBusReq;
  logic [31:0] aluResult;
  logic [2:0]  aluRob;
  logic        aluAck;
  logic        branchDataBusReq;
  logic [31:0] branchResult;
  logic [2:0]  branchRob;
  logic        branchAck;
  logic        validBroadcast;
  logic [31:0] valueBroadcast;
  logic [2:0]  robBroadcast;
  logic [7:0]  conflictCount;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.WIDTH(31), .ROB(2)) dut (
    .clk(clk), .reset(reset), .redirect(redirect),
    .aluDataBusReq(aluDataBusReq), .aluResult(aluResult), .aluRob(aluRob), .aluAck(aluAck),
    .branchDataBusReq(branchDataBusReq), .branchResult(branchResult), .branchRob(branchRob),
    .branchAck(branchAck),
    .validBroadcast(validBroadcast), .valueBroadcast(valueBroadcast),
    .robBroadcast(robBroadcast), .conflictCount(conflictCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        aReq;
    logic [31:0] aVal;
    logic [2:0]  aRob;
    logic        bReq;
    logic [31:0] bVal;
    logic [2:0]  bRob;
    logic        redir;
    logic        eAAck;
    logic        eBAck;
    logic        eValid;
    logic [31:0] eVal;
    logic [2:0]  eRob;
    logic [7:0]  eCnt;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] val;
    logic [2:0]  rob;
  } exp_t;

  exp_t  sbq[$];
  vec_t  vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic aReq, input logic [31:0] aVal, input logic [2:0] aRob,
                              input logic bReq, input logic [31:0] bVal, input logic [2:0] bRob,
                              input logic redir, input logic eA, input logic eB,
                              input logic eV, input logic [31:0] eVal, input logic [2:0] eRob,
                              input logic [7:0] eCnt);
    vec_t t;
    t.aReq = aReq; t.aVal = aVal; t.aRob = aRob;
    t.bReq = bReq; t.bVal = bVal; t.bRob = bRob;
    t.redir = redir; t.eAAck = eA; t.eBAck = eB;
    t.eValid = eV; t.eVal = eVal; t.eRob = eRob; t.eCnt = eCnt;
    return t;
  endfunction

  task automatic popCheck(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb: got empty scoreboard expected entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_valid"}, 64'(validBroadcast), 64'(e.v));
      if (e.v) begin
        chk({tag, "_value"}, 64'(valueBroadcast), 64'(e.val));
        chk({tag, "_rob"},   64'(robBroadcast),   64'(e.rob));
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    int   k;
    // aReq aVal aRob bReq bVal bRob redir | aAck bAck valid value rob count
    vecs[0]  = mk(1, 32'h05, 3, 0, 32'h00, 0, 0, 1, 0, 1, 32'h05, 3, 0);
    vecs[1]  = mk(0, 32'h00, 0, 0, 32'h00, 0, 0, 0, 0, 0, 32'h05, 3, 0);
    vecs[2]  = mk(1, 32'h11, 1, 1, 32'h22, 2, 0, 1, 1, 1, 32'h22, 2, 1);
    vecs[3]  = mk(0, 32'h00, 0, 0, 32'h00, 0, 0, 0, 0, 1, 32'h11, 1, 1);
    vecs[4]  = mk(1, 32'h30, 0, 1, 32'h40, 5, 0, 1, 1, 1, 32'h40, 5, 2);
    vecs[5]  = mk(1, 32'h44, 4, 1, 32'h50, 6, 0, 0, 1, 1, 32'h30, 0, 3);
    vecs[6]  = mk(1, 32'h44, 4, 0, 32'h00, 0, 0, 1, 0, 1, 32'h50, 6, 4);
    vecs[7]  = mk(0, 32'h00, 0, 0, 32'h00, 0, 0, 0, 0, 1, 32'h44, 4, 4);
    vecs[8]  = mk(0, 32'h00, 0, 0, 32'h00, 0, 0, 0, 0, 0, 32'h44, 4, 4);
    vecs[9]  = mk(1, 32'h60, 1, 1, 32'h70, 2, 0, 1, 1, 1, 32'h70, 2, 5);
    vecs[10] = mk(1, 32'h61, 3, 1, 32'h71, 5, 1, 0, 0, 0, 32'h70, 2, 5);
    vecs[11] = mk(0, 32'h00, 0, 1, 32'h80, 6, 0, 0, 1, 1, 32'h80, 6, 5);
    vecs[12] = mk(0, 32'h00, 0, 0, 32'h00, 0, 0, 0, 0, 0, 32'h80, 6, 5);

    reset = 1'b0; redirect = 1'b0;
    aluDataBusReq = 1'b0; aluResult = '0; aluRob = '0;
    branchDataBusReq = 1'b0; branchResult = '0; branchRob = '0;
    #2;
    chk("rst_valid", 64'(validBroadcast), 64'd0);
    chk("rst_value", 64'(valueBroadcast), 64'd0);
    chk("rst_rob",   64'(robBroadcast),   64'd0);
    chk("rst_count", 64'(conflictCount),  64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      aluDataBusReq    = vecs[i].aReq; aluResult    = vecs[i].aVal; aluRob    = vecs[i].aRob;
      branchDataBusReq = vecs[i].bReq; branchResult = vecs[i].bVal; branchRob = vecs[i].bRob;
      redirect         = vecs[i].redir;
      e.v = vecs[i].eValid; e.val = vecs[i].eVal; e.rob = vecs[i].eRob;
      sbq.push_back(e);
      #1;
      chk($sformatf("v%0d_aluAck", i),    64'(aluAck),    64'(vecs[i].eAAck));
      chk($sformatf("v%0d_branchAck", i), 64'(branchAck), 64'(vecs[i].eBAck));
      @(posedge clk); #1;
      popCheck($sformatf("v%0d", i));
      chk($sformatf("v%0d_value_hold", i), 64'(valueBroadcast), 64'(vecs[i].eVal));
      chk($sformatf("v%0d_count", i),      64'(conflictCount),  64'(vecs[i].eCnt));
    end

    // Continuous contention: broadcasts alternate ALU/branch starting with ALU.
    begin
      int ai = 0;
      int bi = 0;
      redirect = 1'b0;
      for (int c = 0; c < 9; c++) begin
        aluDataBusReq    = (c < 8);
        aluResult        = 32'h100 + 32'(ai);
        aluRob           = 3'(ai);
        branchDataBusReq = (c < 8);
        branchResult     = 32'h200 + 32'(bi);
        branchRob        = 3'(7 - bi);
        k = c / 2;
        e.v   = 1'b1;
        e.val = (c % 2 == 0) ? 32'h100 + 32'(k) : 32'h200 + 32'(k);
        e.rob = (c % 2 == 0) ? 3'(k) : 3'(7 - k);
        sbq.push_back(e);
        #1;
        chk($sformatf("alt%0d_aluAck", c), 64'(aluAck),
            64'((c == 0) || (c < 8 && c % 2 == 1)));
        chk($sformatf("alt%0d_branchAck", c), 64'(branchAck),
            64'((c == 0) || (c < 8 && c % 2 == 0)));
        if (aluAck)    ai++;
        if (branchAck) bi++;
        @(posedge clk); #1;
        popCheck($sformatf("alt%0d", c));
      end
      chk("alt_count", 64'(conflictCount), 64'd13);
      e.v = 1'b0; e.val = '0; e.rob = '0;
      sbq.push_back(e);
      @(posedge clk); #1;
      popCheck("alt_idle");
    end

    // Saturation of the contention counter.
    aluDataBusReq = 1'b1; branchDataBusReq = 1'b1;
    for (int c = 0; c < 300; c++) begin
      aluResult    = 32'h1000 + 32'(c);
      branchResult = 32'h2000 + 32'(c);
      @(posedge clk); #1;
    end
    chk("sat_count", 64'(conflictCount),  64'd255);
    chk("sat_valid", 64'(validBroadcast), 64'd1);

    // Asynchronous reset between clock edges.
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid", 64'(validBroadcast), 64'd0);
    chk("async_value", 64'(valueBroadcast), 64'd0);
    chk("async_rob",   64'(robBroadcast),   64'd0);
    chk("async_count", 64'(conflictCount),  64'd0);
    aluDataBusReq = 1'b0; branchDataBusReq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
